element_delay_sequencer: RTL and testbench

- Generates the full per-element focusing delay table for one transmit/receive line.
- Accumulates increment terms from the next-element increment-term calculator outward from the array centre, on both sides.
- Master of the calculator's initiate/ready/ack handshake; emits one delay per element on a valid/ready stream to the delay-line loader.
- Element count and fixed-point width are parametrised; the previous flow hard-wired 32 steps in the bench.

---
 rtl/element_delay_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_element_delay_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/element_delay_sequencer.sv
// Builds the focusing delay table for one line: centre element first, then
// +n/-n pairs accumulated outward from increment terms fetched from the calculator.
module element_delay_sequencer #(
    parameter int DW_INTEGER  = 18,
    parameter int DW_FRACTION = 6,
    parameter int NUM_STEPS   = 32,
    parameter int IDX_W       = $clog2(NUM_STEPS + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DW_INTEGER+DW_FRACTION-1:0]   d0,
    output logic                                calc_initiate,
    input  logic                                calc_ready,
    output logic                                calc_ack,
    input  logic [DW_INTEGER+DW_FRACTION:0]     calc_term_pos,
    input  logic [DW_INTEGER+DW_FRACTION:0]     calc_term_neg,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DW_INTEGER+DW_FRACTION-1:0]   out_delay,
    output logic                                out_side,
    output logic [IDX_W-1:0]                    out_index,
    output logic                                busy,
    output logic                                done,
    output logic                                sat_flag
);
    localparam int W = DW_INTEGER + DW_FRACTION;

    typedef enum logic [2:0] {
        S_IDLE, S_EMIT_C, S_REQ, S_WAIT, S_ACK, S_EMIT_P, S_EMIT_N, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_pos_q, acc_pos_d, acc_neg_q, acc_neg_d;
    logic [W:0]       term_pos_q, term_pos_d, term_neg_q, term_neg_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_delay_q, out_delay_d;
    logic             out_side_q, out_side_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             calc_initiate_q, calc_initiate_d;
    logic             calc_ack_q, calc_ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W:0]       pos_sum, neg_sum;

    // Returns {clamped, value}; the sum is wide enough that bit W+1 is the sign
    // and bit W alone flags an overflow above the unsigned maximum.
    function automatic logic [W:0] sat_add(input logic [W-1:0] acc, input logic [W:0] term);
        logic signed [W+1:0] sum;
        sum = $signed({2'b00, acc}) + $signed({term[W], term});
        if (sum[W+1])
            return {1'b1, {W{1'b0}}};
        else if (sum[W])
            return {1'b1, {W{1'b1}}};
        else
            return {1'b0, sum[W-1:0]};
    endfunction

    always_comb begin
        state_d         = state_q;
        acc_pos_d       = acc_pos_q;
        acc_neg_d       = acc_neg_q;
        term_pos_d      = term_pos_q;
        term_neg_d      = term_neg_q;
        n_d             = n_q;
        sat_d           = sat_q;
        out_valid_d     = out_valid_q;
        out_delay_d     = out_delay_q;
        out_side_d      = out_side_q;
        out_index_d     = out_index_q;
        calc_initiate_d = 1'b0;
        calc_ack_d      = 1'b0;
        busy_d          = busy_q;
        done_d          = 1'b0;
        pos_sum         = sat_add(acc_pos_q, term_pos_q);
        neg_sum         = sat_add(acc_neg_q, term_neg_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_pos_d   = d0;
                    acc_neg_d   = d0;
                    n_d         = '0;
                    sat_d       = 1'b0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_delay_d = d0;
                    out_side_d  = 1'b0;
                    out_index_d = '0;
                    state_d     = S_EMIT_C;
                end
            end
            S_EMIT_C: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (NUM_STEPS == 0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        n_d             = IDX_W'(1);
                        calc_initiate_d = 1'b1;
                        state_d         = S_REQ;
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (calc_ready) begin
                    term_pos_d = calc_term_pos;
                    term_neg_d = calc_term_neg;
                    calc_ack_d = 1'b1;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                acc_pos_d   = pos_sum[W-1:0];
                acc_neg_d   = neg_sum[W-1:0];
                sat_d       = sat_q | pos_sum[W] | neg_sum[W];
                out_valid_d = 1'b1;
                out_delay_d = pos_sum[W-1:0];
                out_side_d  = 1'b0;
                out_index_d = n_q;
                state_d     = S_EMIT_P;
            end
            S_EMIT_P: begin
                if (out_ready) begin
                    out_delay_d = acc_neg_q;
                    out_side_d  = 1'b1;
                    out_index_d = n_q;
                    state_d     = S_EMIT_N;
                end
            end
            S_EMIT_N: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == IDX_W'(NUM_STEPS)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        n_d             = n_q + IDX_W'(1);
                        calc_initiate_d = 1'b1;
                        state_d         = S_REQ;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            acc_pos_q       <= '0;
            acc_neg_q       <= '0;
            term_pos_q      <= '0;
            term_neg_q      <= '0;
            n_q             <= '0;
            sat_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            out_delay_q     <= '0;
            out_side_q      <= 1'b0;
            out_index_q     <= '0;
            calc_initiate_q <= 1'b0;
            calc_ack_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_pos_q       <= acc_pos_d;
            acc_neg_q       <= acc_neg_d;
            term_pos_q      <= term_pos_d;
            term_neg_q      <= term_neg_d;
            n_q             <= n_d;
            sat_q           <= sat_d;
            out_valid_q     <= out_valid_d;
            out_delay_q     <= out_delay_d;
            out_side_q      <= out_side_d;
            out_index_q     <= out_index_d;
            calc_initiate_q <= calc_initiate_d;
            calc_ack_q      <= calc_ack_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign calc_initiate = calc_initiate_q;
    assign calc_ack      = calc_ack_q;
    assign out_valid     = out_valid_q;
    assign out_delay     = out_delay_q;
    assign out_side      = out_side_q;
    assign out_index     = out_index_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_element_delay_sequencer.sv
// Bench for element_delay_sequencer: calculator stub, stream monitor and a
// clamped-accumulation reference model compared word by word per frame.
module tb_element_delay_sequencer;
    localparam int DWI  = 18;
    localparam int DWF  = 6;
    localparam int NS   = 4;
    localparam int W    = DWI + DWF;
    localparam int IW   = $clog2(NS + 1);
    localparam longint MAXV = (longint'(1) << W) - 1;

    typedef struct packed {
        logic          side;
        logic [IW-1:0] idx;
        logic [W-1:0]  dly;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  d0 = '0;
    logic          calc_initiate, calc_ack, calc_ready;
    logic          stub_ready = 1'b0;
    logic          spur_ready = 1'b0;
    logic [W:0]    term_p = '0;
    logic [W:0]    term_n = '0;
    logic          out_valid, out_side, busy, done, sat_flag;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_delay;
    logic [IW-1:0] out_index;

    int    tests = 0;
    int    fails = 0;
    int    tp[0:NS];
    int    tn[0:NS];
    int    stub_step = 0;
    int    calc_delay = 1;
    int    init_cnt = 0;
    int    ack_cnt = 0;
    int    done_cnt = 0;
    word_t got[$];
    word_t expq[$];

    assign calc_ready = stub_ready | spur_ready;

    always #5 clk = ~clk;

    element_delay_sequencer #(
        .DW_INTEGER(DWI), .DW_FRACTION(DWF), .NUM_STEPS(NS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .d0(d0),
        .calc_initiate(calc_initiate), .calc_ready(calc_ready), .calc_ack(calc_ack),
        .calc_term_pos(term_p), .calc_term_neg(term_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_delay(out_delay),
        .out_side(out_side), .out_index(out_index),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Calculator stub: answers each initiate after calc_delay cycles, holds ready until ack.
    initial forever begin
        @(negedge clk);
        if (!rst && calc_initiate) begin
            stub_step++;
            repeat (calc_delay) @(posedge clk);
            #1;
            if (stub_step <= NS) begin
                term_p = tp[stub_step][W:0];
                term_n = tn[stub_step][W:0];
            end
            stub_ready = 1'b1;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (calc_ack || rst) break;
            end
            @(posedge clk);
            #1;
            stub_ready = 1'b0;
        end
    end

    // Stream monitor: records accepted words, checks hold-while-stalled, counts pulses.
    initial begin
        word_t prev_w;
        word_t w;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    checkOutput("hold_stable", {out_valid, out_side, out_index, out_delay}, {1'b1, prev_w});
                w = {out_side, out_index, out_delay};
                prev_stall = out_valid && !out_ready;
                prev_w = w;
                if (out_valid && out_ready) got.push_back(w);
                if (calc_initiate) begin
                    init_cnt++;
                    checkOutput("no_init_while_valid", out_valid, 0);
                end
                if (calc_ack) ack_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    task automatic buildModel(input longint d0v, output bit sat);
        longint ap, an;
        word_t  w;
        expq.delete();
        sat = 1'b0;
        ap = d0v;
        an = d0v;
        w.side = 1'b0; w.idx = '0; w.dly = d0v[W-1:0];
        expq.push_back(w);
        for (int k = 1; k <= NS; k++) begin
            ap += tp[k];
            an += tn[k];
            if (ap < 0) begin ap = 0; sat = 1'b1; end
            else if (ap > MAXV) begin ap = MAXV; sat = 1'b1; end
            if (an < 0) begin an = 0; sat = 1'b1; end
            else if (an > MAXV) begin an = MAXV; sat = 1'b1; end
            w.side = 1'b0; w.idx = IW'(k); w.dly = ap[W-1:0];
            expq.push_back(w);
            w.side = 1'b1; w.dly = an[W-1:0];
            expq.push_back(w);
        end
    endtask

    task automatic setTerms(input int p, input int n);
        for (int k = 0; k <= NS; k++) begin
            tp[k] = p;
            tn[k] = n;
        end
    endtask

    task automatic setRandomTerms();
        for (int k = 0; k <= NS; k++) begin
            tp[k] = int'($urandom_range(0, 16383)) - 8192;
            tn[k] = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
    task automatic applyStimulus(input longint d0v, input int ready_mode,
                                 input int mid_start, input bit abort);
        bit exp_sat;
        bit seen_done;
        buildModel(d0v, exp_sat);
        got.delete();
        init_cnt = 0; ack_cnt = 0; done_cnt = 0; stub_step = 0;
        @(posedge clk); #1;
        d0 = d0v[W-1:0];
        start = 1'b1;
        out_ready = (ready_mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        d0 = W'($urandom);
        checkOutput("busy_after_start", busy, 1);
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == mid_start);
            if (cyc == mid_start) d0 = W'($urandom);
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
            if (abort && out_valid && out_side && out_index == IW'(2)) begin
                rst = 1'b1;
                #1;
                checkOutput("abort_valid", out_valid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_delay", out_delay, 0);
                checkOutput("abort_index", {out_side, out_index}, 0);
                checkOutput("abort_init_ack", {calc_initiate, calc_ack}, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                checkOutput("abort_no_done", done_cnt, 0);
                checkOutput("abort_idle", {busy, out_valid}, 0);
                return;
            end
        end
        checkOutput("done_seen", seen_done, 1);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", done_cnt, 1);
        checkOutput("word_count", got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) checkOutput($sformatf("word%0d", i), got[i], expq[i]);
        checkOutput("sat_flag", sat_flag, exp_sat);
        checkOutput("init_count", init_cnt, NS);
        checkOutput("ack_count", ack_cnt, NS);
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_outputs", {out_valid, busy, done, calc_initiate, calc_ack, sat_flag}, 0);
        checkOutput("rst_delay", out_delay, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_outputs", {out_valid, busy, done, calc_initiate}, 0);

        // Basic frame, then same frame under 1-of-3 backpressure.
        calc_delay = 1;
        setTerms(64, -32);
        applyStimulus(6400, 0, -1, 1'b0);
        checkOutput("basic_word1", got.size() > 1 ? got[1] : '0, {1'b0, IW'(1), W'(6464)});
        applyStimulus(6400, 1, -1, 1'b0);

        // Saturation toward zero, then toward the maximum.
        setTerms(64, -64);
        applyStimulus(32, 0, -1, 1'b0);
        setTerms(1, -1);
        applyStimulus(MAXV, 2, -1, 1'b0);
        @(posedge clk); #1;
        checkOutput("sat_sticky_after_fin", sat_flag, 1);

        // Start pulsed mid-frame is ignored; this frame also shows sat_flag cleared.
        setRandomTerms();
        applyStimulus(longint'($urandom_range(100000, 1000000)), 0, 8, 1'b0);

        // Slow calculator with a spurious ready pulse while idle.
        @(posedge clk); #1;
        term_p = '1; term_n = '1;
        spur_ready = 1'b1;
        @(posedge clk); #1;
        spur_ready = 1'b0;
        checkOutput("spurious_idle", {busy, calc_ack, out_valid}, 0);
        calc_delay = 20;
        setRandomTerms();
        applyStimulus(longint'($urandom_range(50000, 500000)), 2, -1, 1'b0);

        // Reset during EMIT_N of step 2, then a full frame.
        calc_delay = 1;
        setTerms(100, -100);
        applyStimulus(20000, 0, -1, 1'b1);
        applyStimulus(20000, 0, -1, 1'b0);

        // Random frames with random readiness and calculator latency.
        for (int f = 0; f < 4; f++) begin
            calc_delay = int'($urandom_range(1, 5));
            setRandomTerms();
            applyStimulus(longint'($urandom_range(0, 32'hFFFFFF)), 2, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
